// File: rtl/lcd_hex_writer.sv
// HD44780-style character writer: shows DIGITS hex nibbles, a space, then "OK"/"ER",
// with real EN setup/pulse/hold/wait timing. Define LCD_HEX_WRITER_ADDR_EN to prepend a DDRAM address command.
module lcd_hex_writer #(
  parameter int          DIGITS      = 8,
  parameter int          SETUP_CYC   = 2,
  parameter int          EN_HIGH_CYC = 25,
  parameter int          HOLD_CYC    = 2,
  parameter int          WAIT_CYC    = 2500,
  parameter logic [7:0]  START_ADDR  = 8'h00
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  status,
  output logic                  busy,
  output logic                  done,
  output logic                  LCD_RS,
  output logic                  LCD_RW,
  output logic                  LCD_EN,
  output logic [7:0]            LCD_DATA
);

`ifdef LCD_HEX_WRITER_ADDR_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  localparam int N    = DIGITS + 3 + OFS;
  localparam int M1   = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
  localparam int M2   = (HOLD_CYC > WAIT_CYC) ? HOLD_CYC : WAIT_CYC;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int IW   = $clog2(N + 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT, DONE} state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] value_q;
  logic                status_q, busy_q, done_q, rs_q, en_q;
  logic [7:0]          data_q;
  logic [8:0]          next_chr;
  logic                last;

  // {RS, DATA} for character position idx of the given value/status
  function automatic logic [8:0] char_of(input logic [IW-1:0] idx,
                                         input logic [4*DIGITS-1:0] v,
                                         input logic st);
    int                  d;
    logic [4*DIGITS-1:0] sh;
    logic [3:0]          nib;
    d       = int'(idx) - OFS;
    char_of = {1'b1, 8'h20};
    if (OFS == 1 && idx == '0) begin
      char_of = {1'b0, 8'h80 | {1'b0, START_ADDR[6:0]}};
    end else if (d < DIGITS) begin
      sh      = v << (4 * d);
      nib     = sh[4*DIGITS-1 -: 4];
      char_of = {1'b1, (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib})};
    end else if (d == DIGITS + 1) begin
      char_of = {1'b1, st ? 8'h45 : 8'h4F};
    end else if (d == DIGITS + 2) begin
      char_of = {1'b1, st ? 8'h52 : 8'h4B};
    end
  endfunction

  assign idx_d    = idx_q + IW'(1);
  assign next_chr = char_of(idx_d, value_q, status_q);
  assign last     = (idx_q == IW'(N - 1));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      value_q  <= '0;
      status_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          value_q          <= value;
          status_q         <= status;
          idx_q            <= '0;
          busy_q           <= 1'b1;
          {rs_q, data_q}   <= char_of('0, value, status);
          cnt_q            <= CW'(SETUP_CYC - 1);
          state_q          <= SETUP;
        end
        SETUP: if (cnt_q == '0) begin
          en_q    <= 1'b1;
          cnt_q   <= CW'(EN_HIGH_CYC - 1);
          state_q <= PULSE;
        end else cnt_q <= cnt_q - CW'(1);
        PULSE: if (cnt_q == '0) begin
          en_q    <= 1'b0;
          cnt_q   <= CW'(HOLD_CYC - 1);
          state_q <= HOLD;
        end else cnt_q <= cnt_q - CW'(1);
        HOLD: if (cnt_q == '0) begin
          cnt_q   <= CW'(WAIT_CYC - 1);
          state_q <= WAIT;
        end else cnt_q <= cnt_q - CW'(1);
        WAIT: if (cnt_q == '0) begin
          if (last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q          <= idx_d;
            {rs_q, data_q} <= next_chr;
            cnt_q          <= CW'(SETUP_CYC - 1);
            state_q        <= SETUP;
          end
        end else cnt_q <= cnt_q - CW'(1);
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_EN   = en_q;
  assign LCD_DATA = data_q;

endmodule

// File: doc/lcd_hex_writer.md
Name: lcd_hex_writer

Overview:
- Parametrised successor to the fixed-CRC LCD character writer.
- Takes a run-time value of DIGITS hex nibbles plus a pass/fail flag on a start pulse. Writes them to an HD44780-style character LCD as ASCII: hex digits, a space, then "OK" or "ER".
- Generates real EN strobe timing: setup, pulse width, hold and execution wait. Replaces zero-width combinational strobes.
- Reports busy/done so the upstream CRC checker can sequence multiple writes.

Parameters:
- DIGITS, 8, number of hex nibbles displayed (1..16); value width is 4*DIGITS.
- SETUP_CYC, 2, clocks RS/RW/DATA are stable before EN rises (>=1).
- EN_HIGH_CYC, 25, clocks EN is held high (>=1).
- HOLD_CYC, 2, clocks RS/RW/DATA are held after EN falls (>=1).
- WAIT_CYC, 2500, clocks of execution wait after hold, before the next character (>=1).
- START_ADDR, 8'h00, DDRAM address used by the optional address command.

Ports:
- Clock  input  1  system clock, all logic on rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only when busy=0.
- value  input  4*DIGITS  value to display; latched on accepted start.
- status  input  1  0 = pass ("OK"), 1 = fail ("ER"); latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the last character's wait completes.
- LCD_RS  output  1  register select: 0 = command, 1 = data.
- LCD_RW  output  1  always 0 (write only).
- LCD_EN  output  1  enable strobe, registered.
- LCD_DATA  output  8  character/command byte, registered.

Behaviour:
- Reset values (asynchronous, immediate, also mid-operation): busy=0, done=0, LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA=8'h00. FSM returns to IDLE and the character index clears.
- A reset mid-strobe drops EN in the same instant. There is no resumption after reset; a new start is required.
- FSM states and transitions:
  - IDLE: on start=1, latch value and status, set char index=0, go to SETUP.
  - SETUP: drive RS and DATA for the current character, EN=0, for SETUP_CYC cycles, then go to PULSE.
  - PULSE: EN=1 for EN_HIGH_CYC cycles, then go to HOLD.
  - HOLD: EN=0 with RS/DATA unchanged, for HOLD_CYC cycles, then go to WAIT.
  - WAIT: EN=0 for WAIT_CYC cycles. Then, if this was the last character, go to DONE; otherwise increment the index and go to SETUP.
  - DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE.
- Character sequence (N = DIGITS+3 characters, all with RS=1):
  - index 0..DIGITS-1: nibbles in MSB-first order, value[4*DIGITS-1 -: 4] first.
  - index DIGITS: 8'h20 (space).
  - index DIGITS+1: "O" (8'h4F) if status=0, "E" (8'h45) if status=1.
  - index DIGITS+2: "K" (8'h4B) if status=0, "R" (8'h52) if status=1.
- Hex-to-ASCII mapping: 0-9 -> 8'h30-8'h39; A-F -> 8'h41-8'h46 (uppercase). The mapping is combinational from the latched nibble; no priority chain.
- Timing per character: T = SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+WAIT_CYC.
  - Start accepted at edge k; busy=1 and the first SETUP begins at k+1.
  - done pulses at k+1+N*T.
- Counters:
  - Cycle counter width is $clog2 of the largest of the four timing parameters, plus 1; it reloads at every state entry.
  - Index counter width is $clog2(N+1).
- Simultaneous events:
  - start while busy=1 or in DONE is ignored; it is not queued.
  - Changes on value/status after acceptance have no effect.
  - start in the IDLE cycle directly after DONE is accepted.
- LCD_RW is tied low and never toggles.

Optional Feature:
- Macro LCD_HEX_WRITER_ADDR_EN.
- When defined, one extra command character is prepended at index 0: RS=0, DATA = 8'h80 | START_ADDR[6:0]. It uses identical SETUP/PULSE/HOLD/WAIT timing. N becomes DIGITS+4, and the data characters shift up by one index.
- When undefined, there is no command write, N = DIGITS+3, and START_ADDR is unused.

Test Plan:
1. Reset/idle: hold Reset_n=0 for 3 cycles, release, idle 10 cycles -> all outputs 0, busy=0, no EN edge.
2. Basic write: DIGITS=2, SETUP=1, EN_HIGH=2, HOLD=1, WAIT=3 (T=7); start with value=8'h3A, status=0 at edge 0.
   - EN high during cycles 2-3, 9-10, 16-17, 23-24, 30-31.
   - DATA sequence 8'h33, 8'h41, 8'h20, 8'h4F, 8'h4B, all with RS=1.
   - done pulses at cycle 36 (1+5*7); busy high during cycles 1-35.
3. Fail flag and full nibble range: DIGITS=8, value=32'hF0E1D2C9, status=1.
   - DATA sequence "F0E1D2C9", space, "E", "R".
   - Every EN high lasts exactly EN_HIGH_CYC cycles.
4. Start while busy: issue a second start (value=8'h55) mid-sequence in test 2 -> it is ignored, the output stays "3A OK", and exactly one done pulse occurs.
5. Reset mid-operation: assert Reset_n=0 while EN=1 on character 1.
   - EN drops immediately and busy=0.
   - After release, a start with 8'h7F writes "7F OK" from index 0.
6. With LCD_HEX_WRITER_ADDR_EN and START_ADDR=8'h40:
   - The first strobe has RS=0, DATA=8'hC0, followed by 5 data characters.
   - done pulses at cycle 1+6*T.
